// File: rtl/mem_access_unit_if.sv
// +----------------------------------------------------------------------+
// | mem_access_unit_if: operation encoding and data-memory port, rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_access_unit_pkg;
   typedef enum logic [3:0] {
      MEM_NOP = 4'd0,
      MEM_LB  = 4'd1,
      MEM_LBU = 4'd2,
      MEM_LH  = 4'd3,
      MEM_LHU = 4'd4,
      MEM_LW  = 4'd5,
      MEM_SB  = 4'd6,
      MEM_SH  = 4'd7,
      MEM_SW  = 4'd8
   } mem_oper_t;
endpackage

interface mem_access_unit_if;
   logic        req_o;
   logic        we_o;
   logic [31:0] addr_o;
   logic [3:0]  be_o;
   logic [31:0] wdata_o;
   logic        gnt_i;
   logic        rvalid_i;
   logic [31:0] rdata_i;

   modport master (
      output req_o, we_o, addr_o, be_o, wdata_o,
      input  gnt_i, rvalid_i, rdata_i
   );

   modport slave (
      input  req_o, we_o, addr_o, be_o, wdata_o,
      output gnt_i, rvalid_i, rdata_i
   );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +----------------------------------------------------------------------+
// | mem_access_unit: yarc MEM stage, data-memory access and MEM/WB regs  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter bit STORE_WAIT_RESP = 1'b0
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic [31:0]        alu_result_i,
   input  logic [31:0]        alu_oper2_i,
   input  mem_oper_t          mem_oper_i,
   input  logic               instr_valid_i,
   input  logic               write_rd_i,
   input  logic [4:0]         rd_addr_i,
   input  logic [31:0]        pc_i,
   mem_access_unit_if.master  dmem,
   output logic               stall_o,
   output logic [31:0]        rd_data_o,
   output logic               write_rd_o,
   output logic [4:0]         rd_addr_o,
   output logic               instr_valid_o,
   output logic [31:0]        pc_o,
   output logic               misaligned_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      r_state;
   mem_oper_t   r_oper;
   logic [1:0]  r_off;

   logic        w_mem_op;
   logic        w_is_store;
   logic        w_is_half;
   logic        w_is_word;
   logic [1:0]  w_off;
   logic        w_misaligned;
   logic        w_access;
   logic        w_req;
   logic        w_granted;
   logic        w_store_done;
   logic        w_resp_done;
   logic        w_complete;
   logic [31:0] w_shifted;
   logic [31:0] w_load_data;

   assign w_mem_op     = instr_valid_i && (mem_oper_i != MEM_NOP);
   assign w_is_store   = mem_oper_i inside {MEM_SB, MEM_SH, MEM_SW};
   assign w_is_half    = mem_oper_i inside {MEM_LH, MEM_LHU, MEM_SH};
   assign w_is_word    = mem_oper_i inside {MEM_LW, MEM_SW};
   assign w_off        = alu_result_i[1:0];
   assign w_misaligned = w_mem_op && ((w_is_half && w_off[0]) || (w_is_word && (w_off != 2'b00)));
   assign w_access     = w_mem_op && !w_misaligned;

   // Reset gating keeps the bus and the hazard unit quiet while rstn_i is low.
   assign w_req        = rstn_i && (r_state != ST_RESP) && w_access;
   assign w_granted    = w_req && dmem.gnt_i;
   assign w_store_done = w_granted && w_is_store && !STORE_WAIT_RESP;
   assign w_resp_done  = (r_state == ST_RESP) && dmem.rvalid_i;
   assign w_complete   = w_access ? (w_store_done || w_resp_done) : 1'b1;

   assign stall_o      = rstn_i && w_access && !w_complete;
   assign dmem.req_o   = w_req;
   assign dmem.we_o    = w_req && w_is_store;
   assign dmem.addr_o  = {alu_result_i[31:2], 2'b00};

   always_comb begin
      dmem.be_o    = 4'b1111;
      dmem.wdata_o = alu_oper2_i;
      case (mem_oper_i)
         MEM_SB: begin
            dmem.be_o    = 4'b0001 << w_off;
            dmem.wdata_o = {4{alu_oper2_i[7:0]}};
         end
         MEM_SH: begin
            dmem.be_o    = w_off[1] ? 4'b1100 : 4'b0011;
            dmem.wdata_o = {2{alu_oper2_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Extraction uses the offset/oper captured at grant, not the live inputs.
   assign w_shifted = dmem.rdata_i >> {r_off, 3'b000};

   always_comb begin
      w_load_data = alu_result_i;
      case (r_oper)
         MEM_LB:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         MEM_LBU: w_load_data = {24'd0, w_shifted[7:0]};
         MEM_LH:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         MEM_LHU: w_load_data = {16'd0, w_shifted[15:0]};
         MEM_LW:  w_load_data = dmem.rdata_i;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state       <= ST_IDLE;
         r_oper        <= MEM_NOP;
         r_off         <= 2'b00;
         rd_data_o     <= 32'd0;
         write_rd_o    <= 1'b0;
         rd_addr_o     <= 5'd0;
         instr_valid_o <= 1'b0;
         pc_o          <= 32'd0;
         misaligned_o  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_REQ: begin
               if (w_granted) begin
                  r_oper  <= mem_oper_i;
                  r_off   <= w_off;
                  r_state <= w_store_done ? ST_IDLE : ST_RESP;
               end else if (w_req) begin
                  r_state <= ST_REQ;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RESP: begin
               if (dmem.rvalid_i) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_complete) begin
            rd_data_o     <= (r_state == ST_RESP) ? w_load_data : alu_result_i;
            write_rd_o    <= instr_valid_i && write_rd_i && !w_misaligned;
            rd_addr_o     <= rd_addr_i;
            instr_valid_o <= instr_valid_i;
            pc_o          <= pc_i;
            misaligned_o  <= w_misaligned;
         end else begin
            instr_valid_o <= 1'b0;
            write_rd_o    <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +----------------------------------------------------------------------+
// | tb_mem_access_unit: directed and randomized checks of the MEM stage  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] alu_result, alu_oper2, pc;
   mem_oper_t   mem_oper;
   logic        instr_valid, write_rd;
   logic [4:0]  rd_addr;

   logic        stall0, wrd0, iv0, mis0;
   logic [31:0] rdd0, pc0;
   logic [4:0]  rda0;
   logic        stall1, wrd1, iv1, mis1;
   logic [31:0] rdd1, pc1;
   logic [4:0]  rda1;

   int total = 0;
   int bad   = 0;

   logic [31:0] o_addr, o_wdata;
   logic [3:0]  o_be;
   logic        o_we;
   int          o_stalls;

   mem_access_unit_if bus0 ();
   mem_access_unit_if bus1 ();

   always #5 clk = ~clk;

   mem_access_unit #(.STORE_WAIT_RESP(1'b0)) dut0 (
      .clk_i(clk), .rstn_i(rstn), .alu_result_i(alu_result), .alu_oper2_i(alu_oper2),
      .mem_oper_i(mem_oper), .instr_valid_i(instr_valid), .write_rd_i(write_rd),
      .rd_addr_i(rd_addr), .pc_i(pc), .dmem(bus0), .stall_o(stall0), .rd_data_o(rdd0),
      .write_rd_o(wrd0), .rd_addr_o(rda0), .instr_valid_o(iv0), .pc_o(pc0),
      .misaligned_o(mis0)
   );

   mem_access_unit #(.STORE_WAIT_RESP(1'b1)) dut1 (
      .clk_i(clk), .rstn_i(rstn), .alu_result_i(alu_result), .alu_oper2_i(alu_oper2),
      .mem_oper_i(mem_oper), .instr_valid_i(instr_valid), .write_rd_i(write_rd),
      .rd_addr_i(rd_addr), .pc_i(pc), .dmem(bus1), .stall_o(stall1), .rd_data_o(rdd1),
      .write_rd_o(wrd1), .rd_addr_o(rda1), .instr_valid_o(iv1), .pc_o(pc1),
      .misaligned_o(mis1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int op_size(input mem_oper_t op);
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: return 2;
         MEM_LW, MEM_SW:          return 4;
         default:                 return 1;
      endcase
   endfunction

   function automatic logic [3:0] exp_be(input mem_oper_t op, input int off);
      logic [3:0] be;
      be = 4'b0000;
      if (op inside {MEM_SB, MEM_SH, MEM_SW}) begin
         for (int i = 0; i < 4; i++)
            if (i >= off && i < off + op_size(op)) be[i] = 1'b1;
      end else begin
         be = 4'b1111;
      end
      return be;
   endfunction

   function automatic logic [31:0] exp_wdata(input mem_oper_t op, input logic [31:0] d);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % op_size(op)) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] exp_load(input mem_oper_t op, input int off, input logic [31:0] rd);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
      case (op)
         MEM_LB:  return {{24{b[off][7]}}, b[off]};
         MEM_LBU: return {24'd0, b[off]};
         MEM_LH:  return {{16{b[off+1][7]}}, b[off+1], b[off]};
         MEM_LHU: return {16'd0, b[off+1], b[off]};
         default: return rd;
      endcase
   endfunction

   // One instruction on dut0: grant after gdly cycles, response rdly cycles after grant.
   task automatic run_op(input mem_oper_t op, input logic [31:0] addr, input logic [31:0] data,
                         input logic wr, input logic [4:0] rd, input logic [31:0] pcv,
                         input logic valid, input int gdly, input int rdly, input logic [31:0] rdat);
      int   off, done;
      logic mem, mis, access, is_store, is_load;
      off      = int'(addr[1:0]);
      is_store = op inside {MEM_SB, MEM_SH, MEM_SW};
      is_load  = op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
      mem      = valid && (op != MEM_NOP);
      mis      = mem && ((off % op_size(op)) != 0);
      access   = mem && !mis;
      done     = !access ? 0 : (is_store ? gdly : gdly + rdly);

      mem_oper = op; alu_result = addr; alu_oper2 = data; write_rd = wr;
      rd_addr = rd; pc = pcv; instr_valid = valid;
      o_stalls = 0; o_addr = 32'd0; o_be = 4'd0; o_wdata = 32'd0; o_we = 1'b0;
      for (int k = 0; k <= done; k++) begin
         bus0.gnt_i    = access && (k == gdly);
         bus0.rvalid_i = access && is_load && (k == gdly + rdly);
         bus0.rdata_i  = bus0.rvalid_i ? rdat : $urandom;
         @(negedge clk);
         chk("req", bus0.req_o, access && (k <= gdly));
         if (stall0) o_stalls++;
         if (access && k == gdly) begin
            o_addr = bus0.addr_o; o_be = bus0.be_o; o_wdata = bus0.wdata_o; o_we = bus0.we_o;
         end
         @(posedge clk); #1;
         if (k < done) chk("bubble_valid", iv0, 1'b0);
      end
      bus0.gnt_i = 1'b0; bus0.rvalid_i = 1'b0;

      chk("stall_cycles", o_stalls, done);
      if (access) begin
         chk("addr", o_addr, {addr[31:2], 2'b00});
         chk("be", o_be, exp_be(op, off));
         chk("we", o_we, is_store);
         if (is_store) chk("wdata", o_wdata, exp_wdata(op, data));
      end
      chk("valid_out", iv0, valid);
      chk("write_rd", wrd0, valid && wr && !mis);
      chk("rd_addr", rda0, rd);
      chk("pc", pc0, pcv);
      chk("misaligned", mis0, mis);
      if (valid && !mem)          chk("rd_data_alu", rdd0, addr);
      if (access && is_load)      chk("rd_data_load", rdd0, exp_load(op, off, rdat));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; alu_result = 32'd0; alu_oper2 = 32'd0; pc = 32'd0;
      mem_oper = MEM_LW; instr_valid = 1'b1; write_rd = 1'b1; rd_addr = 5'd0;
      bus0.gnt_i = 1'b0; bus0.rvalid_i = 1'b0; bus0.rdata_i = 32'd0;
      bus1.gnt_i = 1'b0; bus1.rvalid_i = 1'b0; bus1.rdata_i = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", bus0.req_o, 1'b0);
      chk("rst_stall", stall0, 1'b0);
      chk("rst_valid", iv0, 1'b0);
      chk("rst_rd_data", rdd0, 32'd0);
      chk("rst_pc", pc0, 32'd0);
      mem_oper = MEM_NOP; instr_valid = 1'b0;
      rstn = 1'b1;

      // Store that waits for the response (dut1).
      mem_oper = MEM_SW; alu_result = 32'h40; alu_oper2 = $urandom; instr_valid = 1'b1;
      write_rd = 1'b0; rd_addr = 5'd3; pc = 32'h80;
      bus1.gnt_i = 1'b1;
      @(negedge clk); chk("swr_stall_c0", stall1, 1'b1); chk("swr_req_c0", bus1.req_o, 1'b1);
      @(posedge clk); #1; chk("swr_valid_c0", iv1, 1'b0);
      bus1.gnt_i = 1'b0;
      @(negedge clk); chk("swr_stall_c1", stall1, 1'b1); chk("swr_req_c1", bus1.req_o, 1'b0);
      @(posedge clk); #1; chk("swr_valid_c1", iv1, 1'b0);
      bus1.rvalid_i = 1'b1;
      @(negedge clk); chk("swr_stall_c2", stall1, 1'b0);
      @(posedge clk); #1; chk("swr_valid_c2", iv1, 1'b1); chk("swr_pc", pc1, 32'h80);
      bus1.rvalid_i = 1'b0;
      instr_valid = 1'b0; mem_oper = MEM_NOP; rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1; rstn = 1'b1;

      run_op(MEM_NOP, 32'h1234, 32'd0, 1'b1, 5'd5, 32'h100, 1'b1, 0, 0, 32'd0);
      chk("alu_rd_data", rdd0, 32'h1234);
      run_op(MEM_SB, 32'h1003, 32'hAB, 1'b0, 5'd0, 32'h104, 1'b1, 0, 0, 32'd0);
      chk("sb_addr", o_addr, 32'h1000); chk("sb_be", o_be, 4'b1000);
      chk("sb_wdata", o_wdata, 32'hABABABAB); chk("sb_stalls", o_stalls, 0);
      run_op(MEM_LB, 32'h2002, 32'd0, 1'b1, 5'd6, 32'h108, 1'b1, 2, 1, 32'h00F00000);
      chk("lb_stalls", o_stalls, 3); chk("lb_data", rdd0, 32'hFFFFFFF0);
      run_op(MEM_LBU, 32'h2002, 32'd0, 1'b1, 5'd6, 32'h10C, 1'b1, 2, 1, 32'h00F00000);
      chk("lbu_data", rdd0, 32'h000000F0);
      run_op(MEM_LW, 32'h3002, 32'd0, 1'b1, 5'd7, 32'h110, 1'b1, 0, 1, 32'd0);
      chk("lw_mis_flag", mis0, 1'b1); chk("lw_mis_wr", wrd0, 1'b0); chk("lw_mis_stalls", o_stalls, 0);

      // Reset while a load is waiting for its response, then a stale response.
      mem_oper = MEM_LW; alu_result = 32'h100; instr_valid = 1'b1; write_rd = 1'b1;
      rd_addr = 5'd7; pc = 32'h200; bus0.gnt_i = 1'b1;
      @(negedge clk); chk("mid_stall_grant", stall0, 1'b1);
      @(posedge clk); #1; bus0.gnt_i = 1'b0;
      @(negedge clk); chk("mid_req_resp", bus0.req_o, 1'b0);
      rstn = 1'b0; #1;
      chk("mid_rst_req", bus0.req_o, 1'b0); chk("mid_rst_stall", stall0, 1'b0);
      chk("mid_rst_valid", iv0, 1'b0); chk("mid_rst_wr", wrd0, 1'b0);
      chk("mid_rst_pc", pc0, 32'd0); chk("mid_rst_mis", mis0, 1'b0);
      chk("mid_rst_rd_addr", rda0, 5'd0);
      @(posedge clk); #1; rstn = 1'b1;
      bus0.rvalid_i = 1'b1; bus0.rdata_i = $urandom;
      @(negedge clk); chk("stale_req", bus0.req_o, 1'b1); chk("stale_stall", stall0, 1'b1);
      @(posedge clk); #1;
      chk("stale_valid", iv0, 1'b0); chk("stale_wr", wrd0, 1'b0);
      bus0.rvalid_i = 1'b0;
      run_op(MEM_LW, 32'h100, 32'd0, 1'b1, 5'd7, 32'h200, 1'b1, 0, 1, 32'hCAFEF00D);

      for (int n = 0; n < 300; n++) begin
         run_op(mem_oper_t'($urandom_range(0, 8)), $urandom, $urandom, 1'($urandom),
                5'($urandom), $urandom, ($urandom_range(0, 7) != 0),
                $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM stage of the yarc pipeline. It consumes the EX/MEM pipeline registers: the address or rd value, store data, mem_oper, and the rd/valid/pc fields. It drives a request/grant/response data-memory port and produces the MEM/WB pipeline registers. It also generates the stall request back to the hazard unit while a memory transaction is outstanding. It performs byte-lane steering for stores and alignment/sign-extension for loads, and flags misaligned accesses.

Parameters:
STORE_WAIT_RESP, 0, 0: a store completes on the grant cycle. 1: a store also waits for rvalid_i before completing.

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
alu_result_i  input  32  memory address for load/store; rd value otherwise
alu_oper2_i  input  32  store data (forwarded rs2)
mem_oper_i  input  mem_oper_t  MEM_NOP, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
instr_valid_i  input  1  EX/MEM entry holds a real instruction
write_rd_i  input  1  instruction writes rd
rd_addr_i  input  5  destination register
pc_i  input  32  instruction pc
req_o  output  1  bus request
we_o  output  1  1 = store
addr_o  output  32  word-aligned address ({alu_result_i[31:2],2'b00})
be_o  output  4  byte enables
wdata_o  output  32  lane-replicated store data
gnt_i  input  1  request accepted this cycle
rvalid_i  input  1  response valid
rdata_i  input  32  response data (full word)
stall_o  output  1  hold IF..EX/MEM; combinational
rd_data_o  output  32  MEM/WB: value to write to rd
write_rd_o  output  1  MEM/WB write enable
rd_addr_o  output  5  MEM/WB rd
instr_valid_o  output  1  MEM/WB valid
pc_o  output  32  MEM/WB pc
misaligned_o  output  1  MEM/WB: instruction raised a misaligned access

Behaviour:
- Reset (asynchronous, rstn_i=0): FSM goes to IDLE. rd_data_o=0, write_rd_o=0, rd_addr_o=0, instr_valid_o=0, pc_o=0, misaligned_o=0. Combinational outputs req_o, we_o and stall_o are 0 while in reset.
- Memory op (mem_op) = instr_valid_i and mem_oper_i != MEM_NOP.
- Misaligned = (H ops and addr[0]) or (W ops and addr[1:0] != 0).
- FSM states:
  - IDLE: mem_op and aligned → req_o=1. If gnt_i=0, go to REQ. If gnt_i=1 and it is a load (or a store with STORE_WAIT_RESP=1), go to RESP. If gnt_i=1 and it is a store with STORE_WAIT_RESP=0, the store completes this cycle and the FSM stays in IDLE.
  - REQ: req_o=1, and addr/we/be/wdata are held stable. These are driven from the held EX/MEM inputs. On gnt_i, move as in IDLE.
  - RESP: req_o=0. On rvalid_i the operation completes and the FSM goes to IDLE.
- stall_o = 1 in every cycle in which a mem_op is present and does not complete that cycle. stall_o = 0 for non-memory and misaligned instructions.
- Completion edge: MEM/WB registers load rd_data_o, write_rd_o, rd_addr_o, instr_valid_o, pc_o and misaligned_o. Non-memory instructions complete in the cycle they are presented (rd_data_o = alu_result_i). On every non-completing edge, MEM/WB takes a bubble: instr_valid_o=0 and write_rd_o=0.
- Misaligned instruction:
  - no request is issued (req_o=0);
  - it completes immediately with misaligned_o=1 and write_rd_o=0.
- Store lanes, with off = addr[1:0]:
  - SB: be = 4'b0001<<off, wdata = {4{data[7:0]}}.
  - SH: be = off[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111, wdata = data.
- Loads: be = 4'b1111. The word is shifted right by 8*off. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. The byte offset and oper are latched at grant, so extraction uses the latched copy.
- Bus rules:
  - rvalid_i arrives at least 1 cycle after gnt_i, and at most one transaction is outstanding.
  - rvalid_i received in IDLE or REQ is ignored, including a stale response after a mid-transaction reset.
- Latency: a load granted in its first cycle with rvalid_i on the next cycle causes 1 stall cycle. A granted store with STORE_WAIT_RESP=0 causes 0 stall cycles.

Test Plan:
- ALU op, alu_result_i=0x1234, write_rd_i=1, rd 5 → next cycle rd_data_o=0x1234, write_rd_o=1, rd_addr_o=5; stall_o never asserted.
- SB to addr 0x1003, data 0xAB, gnt_i in the same cycle → addr_o=0x1000, be_o=4'b1000, wdata_o=0xABABABAB, stall_o=0.
- LB from 0x2002, gnt delayed 2 cycles, then rdata_i=0x00F00000 → stall_o high 3 cycles; rd_data_o=0xFFFFFFF0. LBU with the same stimulus → rd_data_o=0x000000F0.
- LW to 0x3002 → req_o never asserted; misaligned_o=1, write_rd_o=0, stall_o=0.
- Load granted, then rstn_i pulsed low before rvalid_i, then stale rvalid_i → outputs 0 and the FSM in IDLE; the stale response produces no write.
- STORE_WAIT_RESP=1: SW granted at cycle 0, rvalid_i at cycle 2 → stall_o high for cycles 0-1, then instr_valid_o=1 after cycle 2.
